uart_rx_buf: RTL and testbench
==============================

Name: uart_rx_buf

Overview:
UART receive front end for the SoC.
- Synchronises the asynchronous rxd pin and deserialises 8N1 frames with a mid-bit sampling state machine.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Sits directly upstream of the uart register interface and the core's load path; presents rx_data/rx_data_fresh to it and raises rx_irq toward the interrupt controller.

Parameters:
CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); must be >= 4; benches use 16.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 3, width of rx_count = log2(DEPTH)+1.

Ports:
clk  in  1  single system clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
rxd  in  1  serial input from pin; asynchronous; idles high.
rd_en  in  1  pop head entry this cycle; ignored when FIFO is empty.
err_clr  in  1  clears sticky rx_overrun and rx_frame_err.
rx_data  out  8  head FIFO entry (FWFT); 8'h00 when empty.
rx_data_fresh  out  1  FIFO non-empty.
rx_count  out  CNT_W  entries held, 0..DEPTH.
rx_overrun  out  1  sticky: a completed byte was dropped because the FIFO was full.
rx_frame_err  out  1  sticky: stop bit sampled low.
rx_irq  out  1  rx_data_fresh OR rx_overrun OR rx_frame_err.

Behaviour:
Reset:
- On reset (asynchronous): FIFO empty, rx_count 0, rx_data 8'h00, rx_data_fresh 0, both sticky flags 0, rx_irq 0.
- FSM to IDLE, both synchroniser flops to 1.
- Reset mid-frame discards the partial byte with no flag set.

Synchroniser:
- 2 flops; all FSM decisions use the second flop (rxs).
- This adds 2 cycles of input latency.

FSM states are IDLE, START, DATA, STOP, BREAK. A down-counter bcnt is 0 when a sample is due.
- IDLE: rxs==0 -> START, bcnt = CLK_DIV/2 - 1.
- START: at bcnt==0, if rxs==0 -> DATA with bcnt = CLK_DIV-1 and bit index 0; if rxs==1 -> IDLE (glitch rejected, nothing recorded).
- DATA: at bcnt==0, shift rxs in LSB-first and reload CLK_DIV-1; after bit 7 -> STOP.
- STOP, stop bit sampled 1: byte pushed; -> IDLE.
- STOP, stop bit sampled 0: byte discarded, rx_frame_err set; -> BREAK.
- BREAK: waits for rxs==1, then -> IDLE. A held-low line never re-triggers a frame.

FIFO:
- Read/write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
- A push occurs in the cycle after the stop sample; rx_data_fresh/rx_data/rx_count update on the following clock edge.
- Push while full and no rd_en: byte dropped, rx_overrun set, FIFO contents unchanged.
- Push while full with rd_en in the same cycle: pop and push both occur, no overrun, rx_count stays at DEPTH.
- Push and pop while partially full: rx_count unchanged.
- rd_en while empty: no effect; pointers do not move.

Sticky flags:
- err_clr clears both flags.
- A set event in the same cycle as err_clr wins: the flag stays 1.

Other rules:
- rx_irq is combinational from registered state.
- Bit timing tolerance: sampling at mid-bit tolerates ±~4% baud mismatch. No oversampling majority vote.

Decomposition:
- A shared package/defines file holds the FSM state encodings (3-bit, IDLE=0), the UART frame constants (DATA_BITS=8), and CLK_DIV defaults for the 50 MHz and sim configurations.
- One sub-module is natural: sync_fifo (parameterised width/depth, FWFT, with full/empty/count outputs), reusable by the future uart_tx buffer.
- The synchroniser and FSM stay in uart_rx_buf.

Test Plan:
1. CLK_DIV=16, send 0x55 as 8N1 (start, bits LSB-first, stop=1) -> within 2 cycles after the stop-bit sample: rx_data=8'h55, rx_data_fresh=1, rx_count=1, rx_irq=1; then pulse rd_en for 1 cycle -> rx_count=0, rx_data_fresh=0, rx_data=8'h00.
2. Glitch: drive rxd low for 4 clocks, then high -> FSM returns to IDLE, rx_count=0, no flags set; then send 0xA5 -> received correctly.
3. Frame error: send 0xA3 with stop bit 0, hold rxd low 100 clocks, then high, then send 0x3C -> rx_frame_err=1, only 0x3C in the FIFO (rx_count=1), no phantom byte while the line is held low; err_clr -> flag 0.
4. Overrun, DEPTH=4: send 0x01..0x05 with no reads -> rx_count=4, rx_overrun=1; pops return 0x01,0x02,0x03,0x04 in order.
5. Full with simultaneous pop: fill 4 bytes, then assert rd_en exactly in the push cycle of byte 0x77 -> rx_overrun stays 0, rx_count=4, last pop yields 0x77.
6. Reset mid-frame: assert reset during DATA bit 3 of 0xF0, release, send 0x12 -> all outputs at reset values during reset; afterwards only 0x12 is received, no flags.

Source files
------------

// File: rtl/uart_rx_buf_pkg.sv
// Shared constants and FSM encoding for the UART receive path.
package uart_rx_buf_pkg;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned CLK_DIV_50MHZ = 434;  // 50 MHz / 115200 baud
  localparam int unsigned CLK_DIV_SIM   = 16;   // short bit time for simulation

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_buf_sync_fifo.sv
// Parameterised first-word-fall-through FIFO with full/empty/count status.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = CNT_W'(wptr_q - rptr_q);
  assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pop only when data is present; a push while full is accepted only if a pop frees a slot.
  always_comb begin
    do_rd  = rd_en & ~empty;
    do_wr  = wr_en & (~full | do_rd);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART 8N1 receiver: rxd synchroniser, mid-bit sampling FSM, FWFT byte buffer
// and sticky error flags feeding a combined interrupt.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_50MHZ,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       rx_data,
  output logic             rx_data_fresh,
  output logic [CNT_W-1:0] rx_count,
  output logic             rx_overrun,
  output logic             rx_frame_err,
  output logic             rx_irq
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(DATA_BITS);

  logic                 rx_meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic                 frame_set;
  logic                 ovr_set;
  logic                 overrun_q, overrun_d;
  logic                 frame_q, frame_d;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchroniser for the asynchronous pin; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Frame decoder: bcnt counts down to the next mid-bit sample point.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          bcnt_d  = BW'(CLK_DIV / 2 - 1);
        end
      end
      ST_START: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else if (!rxs_q) begin
          state_d = ST_DATA;
          bcnt_d  = BW'(CLK_DIV - 1);
          bit_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bcnt_d  = BW'(CLK_DIV - 1);
          bit_d   = bit_q + IW'(1);
          if (bit_q == IW'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else if (rxs_q) begin
          push_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_set = 1'b1;
          state_d   = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame decoder state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  // Sticky flags: a set event outranks err_clr in the same cycle.
  always_comb begin
    ovr_set   = push_q & fifo_full & ~rd_en;
    overrun_d = ovr_set | (overrun_q & ~err_clr);
    frame_d   = frame_set | (frame_q & ~err_clr);
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_count)
  );

  assign rx_data_fresh = ~fifo_empty;
  assign rx_overrun    = overrun_q;
  assign rx_frame_err  = frame_q;
  assign rx_irq        = rx_data_fresh | overrun_q | frame_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf with a byte scoreboard queue.
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int unsigned CLK_DIV = CLK_DIV_SIM;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 3;

  logic             clk;
  logic             reset;
  logic             rxd;
  logic             rd_en;
  logic             err_clr;
  logic [7:0]       rx_data;
  logic             rx_data_fresh;
  logic [CNT_W-1:0] rx_count;
  logic             rx_overrun;
  logic             rx_frame_err;
  logic             rx_irq;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [7:0]  exp_q[$];

  uart_rx_buf #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .rd_en         (rd_en),
    .err_clr       (err_clr),
    .rx_data       (rx_data),
    .rx_data_fresh (rx_data_fresh),
    .rx_count      (rx_count),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err),
    .rx_irq        (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame starting just after a clock edge. With pop_at_push the
  // bench asserts rd_en in the push cycle (11 edges into the stop bit) and checks
  // the head entry being popped there.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pop_at_push);
    logic [9:0] frame;
    frame = {stop_v, b, 1'b0};
    if (stop_v && (exp_q.size() < DEPTH || pop_at_push)) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        if (pop_at_push && i == 9 && c == 11) begin
          total_cnt++;
          if (exp_q.size() == 0)
            $display("FAIL push_pop_head: scoreboard empty, got %h", rx_data);
          else if (rx_data !== exp_q[0])
            $display("FAIL push_pop_head: got %h want %h", rx_data, exp_q[0]);
          else pass_cnt++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          rd_en = 1'b1;
        end
        if (pop_at_push && i == 9 && c == 12) rd_en = 1'b0;
        tick(1);
      end
    end
  endtask

  // Pops the head entry, returning what was presented before the pop.
  task automatic pop_byte(output logic fresh, output logic [7:0] data);
    fresh = rx_data_fresh;
    data  = rx_data;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    total_cnt++;
    if ({rx_data, rx_data_fresh, rx_count, rx_overrun, rx_frame_err, rx_irq} !== 15'h0)
      $display("FAIL reset_outputs: data=%h fresh=%b count=%0d ovr=%b ferr=%b irq=%b want all 0",
               rx_data, rx_data_fresh, rx_count, rx_overrun, rx_frame_err, rx_irq);
    else pass_cnt++;
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_single_byte();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'h55, 1'b1, 1'b0);
    total_cnt++;
    if (rx_data !== 8'h55 || rx_data_fresh !== 1'b1 || rx_count !== 3'd1 || rx_irq !== 1'b1)
      $display("FAIL single_rx: data=%h fresh=%b count=%0d irq=%b want 55/1/1/1",
               rx_data, rx_data_fresh, rx_count, rx_irq);
    else pass_cnt++;
    e = exp_q.pop_front();
    pop_byte(f, d);
    total_cnt++;
    if (d !== e) $display("FAIL single_pop: got %h want %h", d, e);
    else pass_cnt++;
    total_cnt++;
    if (rx_count !== 3'd0 || rx_data_fresh !== 1'b0 || rx_data !== 8'h00 || rx_irq !== 1'b0)
      $display("FAIL single_empty: count=%0d fresh=%b data=%h irq=%b want 0/0/00/0",
               rx_count, rx_data_fresh, rx_data, rx_irq);
    else pass_cnt++;
    // rd_en on an empty FIFO must not move the pointers
    rd_en = 1'b1; tick(2); rd_en = 1'b0; tick(1);
    total_cnt++;
    if (rx_count !== 3'd0 || rx_data_fresh !== 1'b0)
      $display("FAIL empty_read: count=%0d fresh=%b want 0/0", rx_count, rx_data_fresh);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    rxd = 1'b0; tick(4); rxd = 1'b1; tick(30);
    total_cnt++;
    if (rx_count !== 3'd0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0 || rx_irq !== 1'b0)
      $display("FAIL glitch_reject: count=%0d ovr=%b ferr=%b irq=%b want 0/0/0/0",
               rx_count, rx_overrun, rx_frame_err, rx_irq);
    else pass_cnt++;
    send_frame(8'hA5, 1'b1, 1'b0);
    e = exp_q.pop_front();
    pop_byte(f, d);
    total_cnt++;
    if (f !== 1'b1 || d !== e) $display("FAIL glitch_next: got fresh=%b data=%h want 1/%h", f, d, e);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'hA3, 1'b0, 1'b0);
    tick(100);
    total_cnt++;
    if (rx_count !== 3'd0 || rx_frame_err !== 1'b1 || rx_irq !== 1'b1)
      $display("FAIL ferr_held_low: count=%0d ferr=%b irq=%b want 0/1/1", rx_count, rx_frame_err, rx_irq);
    else pass_cnt++;
    rxd = 1'b1; tick(5);
    send_frame(8'h3C, 1'b1, 1'b0);
    total_cnt++;
    if (rx_count !== 3'd1) $display("FAIL ferr_count: got %0d want 1", rx_count);
    else pass_cnt++;
    e = exp_q.pop_front();
    pop_byte(f, d);
    total_cnt++;
    if (d !== e) $display("FAIL ferr_data: got %h want %h", d, e);
    else pass_cnt++;
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    total_cnt++;
    if (rx_frame_err !== 1'b0 || rx_irq !== 1'b0)
      $display("FAIL ferr_clear: ferr=%b irq=%b want 0/0", rx_frame_err, rx_irq);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0);
    total_cnt++;
    if (rx_count !== 3'd4 || rx_overrun !== 1'b1)
      $display("FAIL ovr_state: count=%0d ovr=%b want 4/1", rx_count, rx_overrun);
    else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      e = exp_q.pop_front();
      pop_byte(f, d);
      total_cnt++;
      if (f !== 1'b1 || d !== e) $display("FAIL ovr_pop%0d: got fresh=%b data=%h want 1/%h", n, f, d, e);
      else pass_cnt++;
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    total_cnt++;
    if (rx_overrun !== 1'b0 || rx_count !== 3'd0 || rx_irq !== 1'b0)
      $display("FAIL ovr_clear: ovr=%b count=%0d irq=%b want 0/0/0", rx_overrun, rx_count, rx_irq);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    total_cnt++;
    if (rx_overrun !== 1'b0 || rx_count !== 3'd4)
      $display("FAIL full_pop_state: ovr=%b count=%0d want 0/4", rx_overrun, rx_count);
    else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      e = exp_q.pop_front();
      pop_byte(f, d);
      total_cnt++;
      if (f !== 1'b1 || d !== e) $display("FAIL full_pop%0d: got fresh=%b data=%h want 1/%h", n, f, d, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (d !== 8'h77) $display("FAIL full_pop_last: got %h want 77", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic       f;
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'h99, 1'b1, 1'b0);
    // 0xF0: start bit then data bits 0..2 (all 0), reset half-way through bit 3
    rxd = 1'b0;
    tick(CLK_DIV * 4 + CLK_DIV / 2);
    reset = 1'b1;
    #2;
    total_cnt++;
    if ({rx_data, rx_data_fresh, rx_count, rx_overrun, rx_frame_err, rx_irq} !== 15'h0)
      $display("FAIL midframe_reset: data=%h fresh=%b count=%0d ovr=%b ferr=%b irq=%b want all 0",
               rx_data, rx_data_fresh, rx_count, rx_overrun, rx_frame_err, rx_irq);
    else pass_cnt++;
    exp_q.delete();
    tick(3);
    rxd = 1'b1;
    reset = 1'b0;
    tick(20);
    send_frame(8'h12, 1'b1, 1'b0);
    total_cnt++;
    if (rx_count !== 3'd1 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0)
      $display("FAIL midframe_after: count=%0d ovr=%b ferr=%b want 1/0/0", rx_count, rx_overrun, rx_frame_err);
    else pass_cnt++;
    e = exp_q.pop_front();
    pop_byte(f, d);
    total_cnt++;
    if (d !== e) $display("FAIL midframe_data: got %h want %h", d, e);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
